// File: rtl/mac_fifo_ctrl_if.sv
// Bundle between the dot-product MAC controller, its two operand FIFOs and the
// result consumer. The controller uses the slave modport; the environment uses master.
interface mac_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int LEN_WIDTH  = 8
);
    logic                  start;
    logic [LEN_WIDTH-1:0]  len;
    logic                  busy;
    logic                  a_n_empty;
    logic                  a_RE;
    logic [DATA_WIDTH-1:0] a_Dout;
    logic                  b_n_empty;
    logic                  b_RE;
    logic [DATA_WIDTH-1:0] b_Dout;
    logic                  res_valid;
    logic                  res_ready;
    logic [ACC_WIDTH-1:0]  res_data;
    logic                  res_ovf;
    logic [1:0]            state_dbg;

    // Result handshake: res_data/res_ovf are held stable while res_valid=1 and the
    // transfer happens on the rising edge where res_valid=1 and res_ready=1.
    // FIFO side: RE pops one entry; the entry appears on Dout one cycle later.
    modport master (
        output start, len, a_n_empty, a_Dout, b_n_empty, b_Dout, res_ready,
        input  busy, a_RE, b_RE, res_valid, res_data, res_ovf, state_dbg
    );
    modport slave (
        input  start, len, a_n_empty, a_Dout, b_n_empty, b_Dout, res_ready,
        output busy, a_RE, b_RE, res_valid, res_data, res_ovf, state_dbg
    );
endinterface

// File: rtl/mac_fifo_ctrl.sv
// Dot-product engine: pops operand pairs from two registered-output FIFOs,
// accumulates unsigned products and offers the sum on a valid/ready port.
module mac_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int LEN_WIDTH  = 8
) (
    input logic clk,
    input logic rst_n,
    mac_fifo_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [LEN_WIDTH-1:0]    issued;
    logic [LEN_WIDTH-1:0]    consumed;
    logic [ACC_WIDTH-1:0]    acc;
    logic                    ovf;
    logic                    pop_d;
    logic                    busy_q;
    logic                    valid_q;
    logic                    pop;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [ACC_WIDTH:0]      sum;

    // Both FIFOs are popped in lockstep so operand pairs can never slip apart.
    assign pop  = (state == RUN) && bus.a_n_empty && bus.b_n_empty && (issued < len_q);
    assign prod = bus.a_Dout * bus.b_Dout;
    assign sum  = {1'b0, acc} + (ACC_WIDTH+1)'(prod);

    assign bus.a_RE      = pop;
    assign bus.b_RE      = pop;
    assign bus.busy      = busy_q;
    assign bus.res_valid = valid_q;
    assign bus.res_data  = acc;
    assign bus.res_ovf   = ovf;
    assign bus.state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            len_q    <= '0;
            issued   <= '0;
            consumed <= '0;
            acc      <= '0;
            ovf      <= 1'b0;
            pop_d    <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            pop_d <= pop;
            if (pop) issued <= issued + LEN_WIDTH'(1);
            // Dout is registered, so the pair popped last cycle is on the bus now.
            if (pop_d) begin
                acc      <= sum[ACC_WIDTH-1:0];
                consumed <= consumed + LEN_WIDTH'(1);
                if (sum[ACC_WIDTH]) ovf <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        len_q    <= bus.len;
                        issued   <= '0;
                        consumed <= '0;
                        acc      <= '0;
                        ovf      <= 1'b0;
                        busy_q   <= 1'b1;
                        if (bus.len != '0) begin
                            state <= RUN;
                        end else begin
                            state   <= DONE;
                            valid_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pop && (issued + LEN_WIDTH'(1) == len_q)) state <= DRAIN;
                end
                DRAIN: begin
                    if (consumed == len_q) begin
                        state   <= DONE;
                        valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_fifo_ctrl.sv
// Directed bench for mac_fifo_ctrl: a 24-bit-accumulator instance fed by small
// FIFO models, plus a 16-bit-accumulator instance for the wrap/overflow case.
module tb_mac_fifo_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mac_fifo_ctrl_if #(.DATA_WIDTH(8), .ACC_WIDTH(24), .LEN_WIDTH(8)) bus1 ();
    mac_fifo_ctrl_if #(.DATA_WIDTH(8), .ACC_WIDTH(16), .LEN_WIDTH(8)) bus2 ();

    mac_fifo_ctrl #(.DATA_WIDTH(8), .ACC_WIDTH(24), .LEN_WIDTH(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));
    mac_fifo_ctrl #(.DATA_WIDTH(8), .ACC_WIDTH(16), .LEN_WIDTH(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // FIFO models for dut1: pointers never wrap within this short run
    logic [7:0] a_mem [64];
    logic [7:0] b_mem [64];
    int a_wr, a_rd, b_wr, b_rd;

    initial begin
        a_wr = 0; b_wr = 0; a_rd = 0; b_rd = 0;
    end

    assign bus1.a_n_empty = (a_wr != a_rd);
    assign bus1.b_n_empty = (b_wr != b_rd);

    always @(posedge clk) begin
        if (bus1.a_RE && a_wr != a_rd) begin
            bus1.a_Dout <= a_mem[a_rd];
            a_rd        <= a_rd + 1;
        end
        if (bus1.b_RE && b_wr != b_rd) begin
            bus1.b_Dout <= b_mem[b_rd];
            b_rd        <= b_rd + 1;
        end
    end

    // dut2 sees two always-full FIFOs holding 255
    assign bus2.a_n_empty = 1'b1;
    assign bus2.b_n_empty = 1'b1;
    assign bus2.a_Dout    = 8'd255;
    assign bus2.b_Dout    = 8'd255;

    // scoreboard
    logic [23:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // lockstep pops, and pops only from non-empty FIFOs
    always @(negedge clk) begin
        if (rst_n) begin
            chk("re_equal", 32'(bus1.a_RE), 32'(bus1.b_RE));
            chk("re2_equal", 32'(bus2.a_RE), 32'(bus2.b_RE));
            if (bus1.a_RE === 1'b1)
                chk("re_nonempty", 32'(bus1.a_n_empty & bus1.b_n_empty), 32'd1);
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [7:0] v);
        a_mem[a_wr] = v;
        a_wr = a_wr + 1;
    endtask

    task automatic push_b(input logic [7:0] v);
        b_mem[b_wr] = v;
        b_wr = b_wr + 1;
    endtask

    task automatic flush();
        a_wr = a_rd;
        b_wr = b_rd;
    endtask

    task automatic run_op(input logic [7:0] l, input int exp_lat, input logic exp_ovf,
                          input string tag);
        int cyc;
        logic [23:0] e;
        bus1.start = 1'b1;
        bus1.len   = l;
        tick();
        bus1.start = 1'b0;
        cyc = 1;
        while (bus1.res_valid !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        e = exp_q.pop_front();
        chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_data"}, 32'(bus1.res_data), 32'(e));
        chk({tag, "_ovf"}, 32'(bus1.res_ovf), 32'(exp_ovf));
    endtask

    initial begin
        int base_a, base_b, cyc;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus1.start = 1'b0; bus1.len = '0; bus1.res_ready = 1'b0;
        bus2.start = 1'b0; bus2.len = '0; bus2.res_ready = 1'b0;
        repeat (3) tick();

        chk("rst_busy", 32'(bus1.busy), 32'd0);
        chk("rst_valid", 32'(bus1.res_valid), 32'd0);
        chk("rst_data", 32'(bus1.res_data), 32'd0);
        chk("rst_ovf", 32'(bus1.res_ovf), 32'd0);
        chk("rst_re", 32'(bus1.a_RE), 32'd0);
        chk("rst_state", 32'(bus1.state_dbg), 32'd0);
        rst_n = 1'b1;
        tick();

        // pre-filled dot product: 1*5+2*6+3*7+4*8 = 70, valid len+3 = 7 cycles on
        push_a(8'd1); push_a(8'd2); push_a(8'd3); push_a(8'd4);
        push_b(8'd5); push_b(8'd6); push_b(8'd7); push_b(8'd8);
        bus1.res_ready = 1'b1;
        exp_q.push_back(24'd70);
        run_op(8'd4, 7, 1'b0, "basic");
        chk("basic_busy", 32'(bus1.busy), 32'd1);
        chk("basic_state", 32'(bus1.state_dbg), 32'd3);
        tick();
        chk("basic_accept_valid", 32'(bus1.res_valid), 32'd0);
        chk("basic_accept_busy", 32'(bus1.busy), 32'd0);
        chk("basic_pops", 32'(a_rd), 32'd4);

        // len=0: result next cycle, zero, no pops
        base_a = a_rd;
        exp_q.push_back(24'd0);
        run_op(8'd0, 1, 1'b0, "len0");
        chk("len0_pops", 32'(a_rd - base_a), 32'd0);
        tick();
        chk("len0_idle", 32'(bus1.state_dbg), 32'd0);

        // stalls: A starts with one entry and is refilled every 5 cycles;
        // 7*2 + 9*3 + 11*4 = 85, and the 4th B entry must stay unread
        flush();
        base_a = a_rd; base_b = b_rd;
        push_a(8'd7);
        push_b(8'd2); push_b(8'd3); push_b(8'd4); push_b(8'd6);
        bus1.start = 1'b1; bus1.len = 8'd3;
        tick();
        bus1.start = 1'b0;
        cyc = 1;
        while (bus1.res_valid !== 1'b1 && cyc < 60) begin
            if (cyc == 5) push_a(8'd9);
            if (cyc == 10) push_a(8'd11);
            tick();
            cyc++;
        end
        chk("stall_valid", 32'(bus1.res_valid), 32'd1);
        chk("stall_data", 32'(bus1.res_data), 32'd85);
        chk("stall_pops_a", 32'(a_rd - base_a), 32'd3);
        chk("stall_pops_b", 32'(b_rd - base_b), 32'd3);
        tick();

        // 16-bit accumulator: 2 * 65025 = 130050 -> 0xFC02 with carry out
        bus2.res_ready = 1'b1;
        bus2.start = 1'b1; bus2.len = 8'd2;
        tick();
        bus2.start = 1'b0;
        cyc = 1;
        while (bus2.res_valid !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("wrap_lat", 32'(cyc), 32'd5);
        chk("wrap_data", 32'(bus2.res_data), 32'h0000_FC02);
        chk("wrap_ovf", 32'(bus2.res_ovf), 32'd1);
        chk("wrap_busy", 32'(bus2.busy), 32'd1);
        tick();
        chk("wrap_idle", 32'(bus2.state_dbg), 32'd0);
        // the next accepted start clears the sticky flag: 65025 fits
        bus2.start = 1'b1; bus2.len = 8'd1;
        tick();
        bus2.start = 1'b0;
        cyc = 1;
        while (bus2.res_valid !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("ovfclr_lat", 32'(cyc), 32'd4);
        chk("ovfclr_data", 32'(bus2.res_data), 32'd65025);
        chk("ovfclr_ovf", 32'(bus2.res_ovf), 32'd0);
        tick();

        // back-pressure: 2*4 + 3*5 = 23 held while res_ready=0, start ignored
        flush();
        base_a = a_rd;
        push_a(8'd2); push_a(8'd3);
        push_b(8'd4); push_b(8'd5);
        bus1.res_ready = 1'b0;
        exp_q.push_back(24'd23);
        run_op(8'd2, 5, 1'b0, "hold");
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus1.start = 1'b1; bus1.len = 8'd1;
            end
            tick();
            bus1.start = 1'b0;
            chk("hold_valid", 32'(bus1.res_valid), 32'd1);
            chk("hold_data", 32'(bus1.res_data), 32'd23);
            chk("hold_state", 32'(bus1.state_dbg), 32'd3);
        end
        bus1.res_ready = 1'b1;
        bus1.start = 1'b1; bus1.len = 8'd1;
        tick();
        bus1.start = 1'b0;
        chk("hold_accept_state", 32'(bus1.state_dbg), 32'd0);
        chk("hold_accept_busy", 32'(bus1.busy), 32'd0);
        chk("hold_accept_valid", 32'(bus1.res_valid), 32'd0);
        tick();
        chk("hold_start_ignored", 32'(bus1.state_dbg), 32'd0);
        chk("hold_pops", 32'(a_rd - base_a), 32'd2);

        // reset after 2 of 4 pops, then len=2 from what is left: 3*30 + 4*40 = 250
        flush();
        base_a = a_rd;
        push_a(8'd1); push_a(8'd2); push_a(8'd3); push_a(8'd4);
        push_b(8'd10); push_b(8'd20); push_b(8'd30); push_b(8'd40);
        bus1.start = 1'b1; bus1.len = 8'd4;
        tick();
        bus1.start = 1'b0;
        tick();
        tick();
        chk("rstrun_pops", 32'(a_rd - base_a), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("rstrun_busy", 32'(bus1.busy), 32'd0);
        chk("rstrun_are", 32'(bus1.a_RE), 32'd0);
        chk("rstrun_bre", 32'(bus1.b_RE), 32'd0);
        chk("rstrun_valid", 32'(bus1.res_valid), 32'd0);
        chk("rstrun_data", 32'(bus1.res_data), 32'd0);
        chk("rstrun_ovf", 32'(bus1.res_ovf), 32'd0);
        chk("rstrun_state", 32'(bus1.state_dbg), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        exp_q.push_back(24'd250);
        run_op(8'd2, 5, 1'b0, "after_rst");
        chk("after_rst_pops", 32'(a_rd - base_a), 32'd4);
        tick();
        chk("after_rst_idle", 32'(bus1.state_dbg), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_fifo_ctrl.md
MAC_FIFO_CTRL -- requirements
Module: mac_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, operand width, matching the DATA_WIDTH of the attached 4-entry FIFOs.
REQ-002 The block SHALL have parameter ACC_WIDTH, default 24, accumulator and result width.
REQ-003 The block SHALL have parameter LEN_WIDTH, default 8, width of the dot-product length field.
REQ-004 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge; both attached FIFOs run clk_in = clk_out = clk.
REQ-005 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1, one-cycle request to begin a dot product.
REQ-007 The block SHALL have port len, input, LEN_WIDTH, number of operand pairs, sampled with start.
REQ-008 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-009 The block SHALL have port a_n_empty, input, 1, operand-A FIFO not empty.
REQ-010 The block SHALL have port a_RE, output, 1, operand-A FIFO read enable.
REQ-011 The block SHALL have port a_Dout, input, DATA_WIDTH, operand-A FIFO registered read data.
REQ-012 The block SHALL have port b_n_empty, input, 1, operand-B FIFO not empty.
REQ-013 The block SHALL have port b_RE, output, 1, operand-B FIFO read enable.
REQ-014 The block SHALL have port b_Dout, input, DATA_WIDTH, operand-B FIFO registered read data.
REQ-015 The block SHALL have port res_valid, output, 1, result available.
REQ-016 The block SHALL have port res_ready, input, 1, consumer accepts result.
REQ-017 The block SHALL have port res_data, output, ACC_WIDTH, dot-product result.
REQ-018 The block SHALL have port res_ovf, output, 1, sticky accumulator-overflow flag for the current result.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-020 In IDLE, start=1 with len!=0 SHALL latch len, clear accumulator, issued count, consumed count and res_ovf, and enter RUN next cycle.
REQ-021 In IDLE, start=1 with len==0 SHALL enter DONE with res_data=0 and res_ovf=0.
REQ-022 start SHALL be ignored in every state except IDLE.
REQ-023 In RUN, a_RE and b_RE SHALL be asserted together, combinationally, only when a_n_empty=1, b_n_empty=1 and issued<len; they SHALL never differ.
REQ-024 Each pop SHALL increment issued; when issued reaches len the FSM SHALL move to DRAIN.
REQ-025 Operand data SHALL be taken one cycle after the pop (FIFO Dout is registered); a one-bit pop_d pipeline register SHALL mark the valid operand cycle.
REQ-026 When pop_d=1, the accumulator SHALL add the unsigned product a_Dout*b_Dout, zero-extended, and increment consumed.
REQ-027 Accumulation SHALL wrap modulo 2^ACC_WIDTH; any carry out SHALL set res_ovf, which stays set until the next accepted start.
REQ-028 In DRAIN, the FSM SHALL enter DONE the cycle after consumed reaches len (the final product included); a_RE and b_RE SHALL be 0.
REQ-029 In DONE, res_valid SHALL be 1 and res_data SHALL hold the accumulator, stable until accepted.
REQ-030 res_valid=1 with res_ready=1 SHALL complete the transfer and return the FSM to IDLE next cycle; start in that same cycle is ignored.
REQ-031 A FIFO emptying mid-RUN SHALL stall pops without losing or duplicating any operand; throughput SHALL be one pair per cycle while both FIFOs are non-empty.
REQ-032 Total latency from start to res_valid with pre-filled FIFOs SHALL be len+3 cycles.

Reset
REQ-033 rst_n=0 SHALL asynchronously force IDLE, busy=0, a_RE=0, b_RE=0, res_valid=0, res_data=0, res_ovf=0, accumulator, counters and pop_d=0.
REQ-034 Reset asserted mid-RUN SHALL abandon the operation; no result is produced, and FIFO contents are not restored.

Verification
REQ-035 FIFOs pre-filled A={1,2,3,4}, B={5,6,7,8}, start len=4, res_ready=1 -> res_data=70, res_ovf=0, res_valid asserted 7 cycles after start.
REQ-036 len=3, A holds 1 entry initially, each refilled 5 cycles later, B full -> a_RE/b_RE only while both non-empty, res_data correct, no pop beyond 3.
REQ-037 DATA_WIDTH=8, ACC_WIDTH=16, len=2, A={255,255}, B={255,255} -> res_data=0xFC02 mod 2^16 = 64514, res_ovf=1.
REQ-038 start with len=0 -> res_valid next cycle, res_data=0, no RE pulse.
REQ-039 res_ready held 0 for 10 cycles in DONE, start pulsed -> res_data stable, start ignored, IDLE only after res_ready=1.
REQ-040 rst_n pulsed low during RUN after 2 of 4 pops -> all outputs 0 immediately; a new start len=2 runs correctly from the remaining FIFO entries.
